// File: rtl/dense_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : dense_pkg
//  Brief    : Shared constants, FSM state encoding and configuration record
//             for the dense-layer sequencer and its MAC datapath.
//  Revision : 1.0 - initial release
// ============================================================================
package dense_pkg;

   localparam int MAX_IN  = 42;  // maximum inputs per layer
   localparam int MAX_NEU = 24;  // maximum neurons per layer
   localparam int DW      = 16;  // data width, signed Q8.8
   localparam int WW      = 8;   // weight/bias width, signed int8 (code/256)
   localparam int ACCW    = 32;  // accumulator width
   localparam int WAW     = 10;  // weight address width
   localparam int FRAC    = 8;   // weight scale shift (1/256)

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      BIAS  = 3'd1,
      MAC   = 3'd2,
      WRITE = 3'd3,
      DONE  = 3'd4
   } dense_state_t;

   typedef struct packed {
      logic [5:0] nb_input;
      logic [4:0] nb_neurons;
      logic [4:0] stride;
   } dense_cfg_t;

   // A layer is runnable when both dimensions are in range and the weight
   // rows are at least as wide as the neuron count (no row overlap).
   function automatic logic cfg_valid(input dense_cfg_t c);
      return (c.nb_input != 6'd0) && (c.nb_input <= 6'(MAX_IN)) &&
             (c.nb_neurons != 5'd0) && (c.nb_neurons <= 5'(MAX_NEU)) &&
             (c.stride >= c.nb_neurons);
   endfunction

endpackage
`default_nettype wire

// File: rtl/dense_mac_acc.sv
`default_nettype none
// ============================================================================
//  Module   : dense_mac_acc
//  Brief    : Shared int8 x Q8.8 multiplier with bias-load/accumulate control
//             and Q8.8 result extraction (acc >>> FRAC).
//             Build option DENSE_SEQ_SAT_EN: saturate the result to the DW
//             range instead of two's-complement wrap.
//  Revision : 1.0 - initial release
// ============================================================================
module dense_mac_acc
   import dense_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 load_i,    // acc = (bias << FRAC) + w*x
   input  logic                 acc_en_i,  // acc = acc + w*x
   input  logic signed [WW-1:0] w_i,
   input  logic signed [DW-1:0] x_i,
   input  logic signed [WW-1:0] b_i,
   output logic        [DW-1:0] y_o
);

   localparam int PW = WW + DW;

   logic signed [PW-1:0]   prod;
   logic signed [ACCW-1:0] prod_ext;
   logic signed [ACCW-1:0] bias_ext;
   logic signed [ACCW-1:0] acc_q;
   logic signed [ACCW-1:0] acc_d;

   // Full-precision signed product; both operands sign-extended first.
   assign prod     = PW'(w_i) * PW'(x_i);
   assign prod_ext = ACCW'(prod);
   // Bias is int8 at scale 1/256, so it enters the accumulator pre-shifted.
   assign bias_ext = {{(ACCW-WW-FRAC){b_i[WW-1]}}, b_i, {FRAC{1'b0}}};

   // Next accumulator value: load starts a neuron, accumulate adds a term.
   always_comb begin
      acc_d = acc_q;
      if (load_i) begin
         acc_d = bias_ext + prod_ext;
      end else if (acc_en_i) begin
         acc_d = acc_q + prod_ext;
      end
   end

   // Accumulator register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_q <= '0;
      end else begin
         acc_q <= acc_d;
      end
   end

`ifdef DENSE_SEQ_SAT_EN
   logic [ACCW-FRAC-DW:0] top_bits;
   assign top_bits = acc_q[ACCW-1:FRAC+DW-1];

   // Clamp acc >>> FRAC to the signed DW range when the upper bits are not
   // a pure sign extension.
   always_comb begin
      y_o = acc_q[FRAC +: DW];
      if (!((&top_bits) || !(|top_bits))) begin
         y_o = acc_q[ACCW-1] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
      end
   end
`else
   // Low DW bits of acc >>> FRAC (two's-complement wrap).
   assign y_o = acc_q[FRAC +: DW];
`endif

endmodule
`default_nettype wire

// File: rtl/dense_layer_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : dense_layer_sequencer
//  Brief    : Walks every neuron/input pair of one dense layer, issuing
//             weight/input/bias reads, driving the shared MAC and writing one
//             pre-activation result per neuron.
//             Build option DENSE_SEQ_SAT_EN: saturated result (see MAC).
//  Revision : 1.0 - initial release
// ============================================================================
module dense_layer_sequencer
   import dense_pkg::*;
(
   input  logic           clk,
   input  logic           rst_n,
   input  logic           start,
   input  logic [5:0]     cfg_nb_input,
   input  logic [4:0]     cfg_nb_neurons,
   input  logic [4:0]     cfg_stride,
   output logic           busy,
   output logic           done,
   output logic           cfg_err,
   output logic           w_rd,
   output logic [WAW-1:0] w_addr,
   input  logic [WW-1:0]  w_data,
   output logic           x_rd,
   output logic [5:0]     x_addr,
   input  logic [DW-1:0]  x_data,
   output logic           b_rd,
   output logic [4:0]     b_addr,
   input  logic [WW-1:0]  b_data,
   output logic           y_wr,
   output logic [4:0]     y_addr,
   output logic [DW-1:0]  y_data
);

   dense_state_t   state_q, state_d;
   dense_cfg_t     cfg_q, cfg_d;
   dense_cfg_t     cfg_in;
   logic [4:0]     n_q, n_d;       // current neuron
   logic [5:0]     k_q, k_d;       // input index whose data is arriving
   logic [WAW-1:0] wa_q, wa_d;     // next weight address, stepped by stride
   logic           cfg_err_q, cfg_err_d;
   logic           mac_load, mac_acc;

   assign cfg_in = '{nb_input: cfg_nb_input, nb_neurons: cfg_nb_neurons,
                     stride: cfg_stride};

   // State, latched configuration, counters and the error pulse.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         cfg_q     <= '0;
         n_q       <= '0;
         k_q       <= '0;
         wa_q      <= '0;
         cfg_err_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cfg_q     <= cfg_d;
         n_q       <= n_d;
         k_q       <= k_d;
         wa_q      <= wa_d;
         cfg_err_q <= cfg_err_d;
      end
   end

   // Next-state, counter updates and the state-exclusive strobes/addresses.
   always_comb begin
      state_d   = state_q;
      cfg_d     = cfg_q;
      n_d       = n_q;
      k_d       = k_q;
      wa_d      = wa_q;
      cfg_err_d = 1'b0;
      mac_load  = 1'b0;
      mac_acc   = 1'b0;
      done      = 1'b0;
      w_rd      = 1'b0;
      w_addr    = '0;
      x_rd      = 1'b0;
      x_addr    = '0;
      b_rd      = 1'b0;
      b_addr    = '0;
      y_wr      = 1'b0;
      y_addr    = '0;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               if (cfg_valid(cfg_in)) begin
                  cfg_d   = cfg_in;
                  n_d     = '0;
                  state_d = BIAS;
               end else begin
                  cfg_err_d = 1'b1;
               end
            end
         end
         BIAS: begin
            b_rd    = 1'b1;
            b_addr  = n_q;
            w_rd    = 1'b1;
            x_rd    = 1'b1;
            w_addr  = WAW'(n_q);
            wa_d    = WAW'(n_q) + WAW'(cfg_q.stride);
            k_d     = '0;
            state_d = MAC;
         end
         MAC: begin
            mac_load = (k_q == 6'd0);
            mac_acc  = (k_q != 6'd0);
            if (k_q != cfg_q.nb_input - 6'd1) begin
               w_rd   = 1'b1;
               x_rd   = 1'b1;
               w_addr = wa_q;
               x_addr = k_q + 6'd1;
               wa_d   = wa_q + WAW'(cfg_q.stride);
               k_d    = k_q + 6'd1;
            end else begin
               state_d = WRITE;
            end
         end
         WRITE: begin
            y_wr   = 1'b1;
            y_addr = n_q;
            if (n_q == cfg_q.nb_neurons - 5'd1) begin
               state_d = DONE;
            end else begin
               n_d     = n_q + 5'd1;
               state_d = BIAS;
            end
         end
         DONE: begin
            done    = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign busy    = (state_q != IDLE);
   assign cfg_err = cfg_err_q;

   dense_mac_acc u_mac (
      .clk      (clk),
      .rst_n    (rst_n),
      .load_i   (mac_load),
      .acc_en_i (mac_acc),
      .w_i      (w_data),
      .x_i      (x_data),
      .b_i      (b_data),
      .y_o      (y_data)
   );

endmodule
`default_nettype wire

// File: tb/tb_dense_layer_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_dense_layer_sequencer
//  Brief    : Self-checking bench for dense_layer_sequencer with memory models
//             and an arithmetic reference for each neuron's result.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_dense_layer_sequencer;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic [5:0]  cfg_nb_input;
   logic [4:0]  cfg_nb_neurons;
   logic [4:0]  cfg_stride;
   logic        busy, done, cfg_err;
   logic        w_rd, x_rd, b_rd, y_wr;
   logic [9:0]  w_addr;
   logic [5:0]  x_addr;
   logic [4:0]  b_addr, y_addr;
   logic [7:0]  w_data, b_data;
   logic [15:0] x_data, y_data;

   logic [7:0]  wmem [1024];
   logic [15:0] xmem [64];
   logic [7:0]  bmem [32];

   int          wq[$], xq[$], bq[$], yaq[$];
   logic [15:0] ydq[$];
   int          viol;
   int          tests = 0;
   int          fails = 0;

   dense_layer_sequencer dut (
      .clk(clk), .rst_n(rst_n), .start(start),
      .cfg_nb_input(cfg_nb_input), .cfg_nb_neurons(cfg_nb_neurons),
      .cfg_stride(cfg_stride), .busy(busy), .done(done), .cfg_err(cfg_err),
      .w_rd(w_rd), .w_addr(w_addr), .w_data(w_data),
      .x_rd(x_rd), .x_addr(x_addr), .x_data(x_data),
      .b_rd(b_rd), .b_addr(b_addr), .b_data(b_data),
      .y_wr(y_wr), .y_addr(y_addr), .y_data(y_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Synchronous-read memories: data valid the cycle after the strobe.
   always @(posedge clk) begin
      if (w_rd) w_data <= wmem[w_addr];
      if (x_rd) x_data <= xmem[x_addr];
      if (b_rd) b_data <= bmem[b_addr];
   end

   // Record every access and flag strobes appearing outside their phase.
   always @(posedge clk) begin
      if (rst_n) begin
         if (w_rd !== x_rd) viol++;
         if ((y_wr || done || !busy) && (w_rd || x_rd || b_rd)) viol++;
         if (y_wr && done) viol++;
         if (!busy && (y_wr || done)) viol++;
         if (w_rd) wq.push_back(int'(w_addr));
         if (x_rd) xq.push_back(int'(x_addr));
         if (b_rd) bq.push_back(int'(b_addr));
         if (y_wr) begin
            yaq.push_back(int'(y_addr));
            ydq.push_back(y_data);
         end
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // y = (b*256 + sum_j w[j*S+n]*x[j]) / 256, floored, then reduced to 16 bits.
   function automatic logic [15:0] ref_y(int n, int N, int S);
      longint acc, sh;
      acc = longint'($signed(bmem[n])) * 256;
      for (int j = 0; j < N; j++)
         acc += longint'($signed(wmem[(j*S+n) % 1024])) * longint'($signed(xmem[j]));
      sh = acc >>> 8;
`ifdef DENSE_SEQ_SAT_EN
      if (sh > 32767)  return 16'h7fff;
      if (sh < -32768) return 16'h8000;
`endif
      return sh[15:0];
   endfunction

   task automatic clear_logs();
      wq.delete(); xq.delete(); bq.delete(); yaq.delete(); ydq.delete();
      viol = 0;
   endtask

   task automatic fill_random();
      for (int i = 0; i < 1024; i++) wmem[i] = 8'($urandom);
      for (int i = 0; i < 64; i++)   xmem[i] = 16'($urandom);
      for (int i = 0; i < 32; i++)   bmem[i] = 8'($urandom);
   endtask

   task automatic verify(input int N, input int M, input int S);
      int bad;
      check("y_wr count", yaq.size(), M);
      for (int i = 0; i < M && i < yaq.size(); i++) begin
         check("y_addr", yaq[i], i);
         check("y_data", ydq[i], ref_y(i, N, S));
      end
      check("w_rd count", wq.size(), N*M);
      check("x_rd count", xq.size(), N*M);
      check("b_rd count", bq.size(), M);
      bad = 0;
      for (int n = 0; n < M; n++)
         for (int j = 0; j < N; j++)
            if (n*N+j < wq.size() && n*N+j < xq.size())
               if (wq[n*N+j] != (j*S+n) % 1024 || xq[n*N+j] != j) bad++;
      for (int n = 0; n < M && n < bq.size(); n++)
         if (bq[n] != n) bad++;
      check("read addresses", bad, 0);
      check("strobe exclusivity", viol, 0);
   endtask

   // Start a layer (accepted on edge 0) and measure the cycle in which done is high.
   task automatic run_layer(input int N, input int M, input int S, input bit hammer);
      int cyc;
      clear_logs();
      @(negedge clk);
      cfg_nb_input = 6'(N); cfg_nb_neurons = 5'(M); cfg_stride = 5'(S);
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      check("busy after accept", busy, 1);
      cyc = 0;
      for (int t = 1; t <= 3000; t++) begin
         if (hammer) begin
            start          = 1'($urandom);
            cfg_nb_input   = 6'($urandom);
            cfg_nb_neurons = 5'($urandom);
            cfg_stride     = 5'($urandom);
         end
         @(posedge clk); #1;
         if (done) begin
            cyc = t + 1;
            break;
         end
      end
      start = 1'b0;
      check("done cycle", cyc, M*(N+2)+1);
      verify(N, M, S);
      @(posedge clk); #1;
      check("done one pulse", done, 0);
      check("busy after done", busy, 0);
   endtask

   task automatic bad_cfg(input int N, input int M, input int S);
      @(negedge clk);
      cfg_nb_input = 6'(N); cfg_nb_neurons = 5'(M); cfg_stride = 5'(S);
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      check("cfg_err pulse", cfg_err, 1);
      check("busy on reject", busy, 0);
      check("strobes on reject", {w_rd, x_rd, b_rd, y_wr, done}, 0);
      @(posedge clk); #1;
      check("cfg_err clears", cfg_err, 0);
      check("busy stays low", busy, 0);
   endtask

   initial begin
      rst_n = 1'b0; start = 1'b0;
      cfg_nb_input = '0; cfg_nb_neurons = '0; cfg_stride = '0;
      w_data = '0; x_data = '0; b_data = '0;
      viol = 0;
      for (int i = 0; i < 1024; i++) wmem[i] = '0;
      for (int i = 0; i < 64; i++)   xmem[i] = '0;
      for (int i = 0; i < 32; i++)   bmem[i] = '0;
      repeat (3) @(posedge clk);
      #1;
      check("reset busy/done/err", {busy, done, cfg_err}, 0);
      check("reset strobes", {w_rd, x_rd, b_rd, y_wr}, 0);
      check("reset addresses", {w_addr, x_addr, b_addr, y_addr}, 0);
      check("reset y_data", y_data, 0);
      @(negedge clk);
      rst_n = 1'b1;

      // Small hand-computed layer: 16 + 64 - 64 = 16.
      bmem[0] = 8'd16; wmem[0] = 8'd64; wmem[1] = 8'hE0;
      xmem[0] = 16'd256; xmem[1] = 16'd512;
      run_layer(2, 1, 1, 1'b0);
      check("y_data example", (ydq.size() > 0) ? ydq[0] : 16'hdead, 16);

      // Full 42->24 layer: each result 42*256*1/256 = 42.
      for (int i = 0; i < 1024; i++) wmem[i] = 8'd1;
      for (int i = 0; i < 64; i++)   xmem[i] = 16'd256;
      for (int i = 0; i < 32; i++)   bmem[i] = 8'd0;
      run_layer(42, 24, 24, 1'b0);
      check("y_data last of 42x24", (ydq.size() == 24) ? ydq[23] : 16'hdead, 42);

      // Rejected configurations.
      bad_cfg(0, 4, 4);
      bad_cfg(3, 25, 25);
      bad_cfg(3, 6, 5);
      bad_cfg(43, 2, 2);

      // Random layer with start/config hammered while busy, then back-to-back.
      fill_random();
      begin
         int n, m, s;
         n = $urandom_range(1, 42); m = $urandom_range(1, 24); s = $urandom_range(m, 31);
         run_layer(n, m, s, 1'b1);
         n = $urandom_range(1, 42); m = $urandom_range(1, 24); s = $urandom_range(m, 31);
         run_layer(n, m, s, 1'b0);
         n = $urandom_range(1, 42); m = $urandom_range(1, 24); s = $urandom_range(m, 31);
         run_layer(n, m, s, 1'b1);
      end

      // Asynchronous reset in the MAC phase of neuron 5.
      fill_random();
      clear_logs();
      @(negedge clk);
      cfg_nb_input = 6'd6; cfg_nb_neurons = 5'd8; cfg_stride = 5'd9;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      for (int t = 0; t < 200 && yaq.size() < 5; t++) begin
         @(posedge clk); #1;
      end
      check("writes before reset", yaq.size(), 5);
      @(posedge clk); #3;
      rst_n = 1'b0;
      #1;
      check("async reset ctrl", {busy, done, cfg_err, w_rd, x_rd, b_rd, y_wr}, 0);
      check("async reset addr", {w_addr, x_addr, b_addr, y_addr}, 0);
      check("async reset y_data", y_data, 0);
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (60) @(posedge clk);
      #1;
      check("no writes after abort", yaq.size(), 5);
      check("idle after abort", busy, 0);
      run_layer(6, 8, 9, 1'b0);

      // Large-magnitude layer: saturates or wraps depending on the build.
      for (int i = 0; i < 1024; i++) wmem[i] = 8'd127;
      for (int i = 0; i < 64; i++)   xmem[i] = 16'd32767;
      for (int i = 0; i < 32; i++)   bmem[i] = 8'd127;
      run_layer(42, 2, 2, 1'b0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
`default_nettype wire
